// File: rtl/clock_pkg.sv
// clock_pkg: digit indices, digit limits and BCD helpers
// shared by the LED clock back end.
package clock_pkg;

  localparam logic [2:0] DIG_S1  = 3'd0;
  localparam logic [2:0] DIG_S10 = 3'd1;
  localparam logic [2:0] DIG_M1  = 3'd2;
  localparam logic [2:0] DIG_M10 = 3'd3;
  localparam logic [2:0] DIG_H1  = 3'd4;
  localparam logic [2:0] DIG_H10 = 3'd5;

  localparam logic [3:0] LIM_ONES  = 4'd9;
  localparam logic [3:0] LIM_TENS  = 4'd5;
  localparam logic [3:0] LIM_H10   = 4'd2;
  localparam logic [3:0] LIM_H1_20 = 4'd3;

  // active-low {g,f,e,d,c,b,a}; non-BCD codes blank
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // bit 4 is the carry out
  function automatic logic [4:0] dinc(
    input logic [3:0] d,
    input logic [3:0] lim
  );
    return (d >= lim) ? 5'b1_0000 : {1'b0, d + 4'd1};
  endfunction

  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [23:0] n;
    logic [4:0]  r;
    logic        c;
    n = t;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        r = dinc(n[i*4 +: 4], (i % 2 == 1) ? LIM_TENS : LIM_ONES);
        n[i*4 +: 4] = r[3:0];
        c = r[4];
      end
    end
    if (c) begin
      if (n[23:16] == 8'h23) begin
        n[23:16] = 8'h00;
      end else begin
        r = dinc(n[19:16], LIM_ONES);
        n[19:16] = r[3:0];
        if (r[4]) n[23:20] = n[23:20] + 4'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// seg7_scan: six-digit multiplexer with registered
// anode, segment and decimal-point outputs.
module seg7_scan
  import clock_pkg::*;
#(
  parameter int SCAN_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] digits,
  input  logic        set_mode,
  input  logic [2:0]  cursor,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [3:0]    cur;

  always_comb begin
    cur = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (idx == 3'(i)) cur = digits[i*4 +: 4];
    end
  end

  // an/seg/dp load together so digits never mix
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= 3'd0;
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      if (cnt == CNT_TC) begin
        cnt <= '0;
        idx <= (idx == DIG_H10) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      an  <= ~(8'h01 << idx);
      seg <= seg7(cur);
      dp  <= !((idx == DIG_M1) || (idx == DIG_H1) ||
               (set_mode && idx == cursor));
    end
  end

endmodule

// File: rtl/clock_core.sv
// clock_core: BCD hh:mm:ss timekeeping with validated
// digit loads, driving the seg7_scan display.
module clock_core
  import clock_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_mode,
  input  logic        load,
  input  logic [2:0]  load_sel,
  input  logic [3:0]  load_val,
  output logic [23:0] time_bcd,
  output logic        sec_tick,
  output logic        load_err,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc;
  logic          ld_ok;
  logic [23:0]   ld_time;

  always_comb begin
    ld_ok   = 1'b0;
    ld_time = time_bcd;
    case (load_sel)
      DIG_S1, DIG_M1:   ld_ok = load_val <= LIM_ONES;
      DIG_S10, DIG_M10: ld_ok = load_val <= LIM_TENS;
      DIG_H1: ld_ok = load_val <= ((time_bcd[23:20] == 4'd2) ?
                                   LIM_H1_20 : LIM_ONES);
      DIG_H10:          ld_ok = load_val <= LIM_H10;
      default:          ld_ok = 1'b0;
    endcase
    for (int i = 0; i < 6; i++) begin
      if (load_sel == 3'(i)) ld_time[i*4 +: 4] = load_val;
    end
    // 2x hours must stay within 23
    if (load_sel == DIG_H10 && load_val == 4'd2 &&
        time_bcd[19:16] > LIM_H1_20)
      ld_time[19:16] = 4'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      time_bcd <= 24'h0;
      sec_tick <= 1'b0;
      load_err <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      load_err <= 1'b0;
      if (set_mode) begin
        presc <= '0;
        if (load) begin
          if (ld_ok) time_bcd <= ld_time;
          else       load_err <= 1'b1;
        end
      end else if (presc == PRE_TC) begin
        presc    <= '0;
        time_bcd <= bcd_inc(time_bcd);
        sec_tick <= 1'b1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  seg7_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .digits   (time_bcd),
    .set_mode (set_mode),
    .cursor   (load_sel),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

endmodule

// File: tb/tb_clock_core.sv
// tb_clock_core: table-driven and directed checks of
// clock_core with CLK_HZ=10, SCAN_DIV=4.
module tb_clock_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_mode = 1'b0;
  logic        load = 1'b0;
  logic [2:0]  load_sel = 3'd0;
  logic [3:0]  load_val = 4'd0;
  logic [23:0] time_bcd;
  logic        sec_tick;
  logic        load_err;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_cmp = 0;
  int n_bad = 0;

  clock_core #(
    .CLK_HZ   (10),
    .SCAN_DIV (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .set_mode (set_mode),
    .load     (load),
    .load_sel (load_sel),
    .load_val (load_val),
    .time_bcd (time_bcd),
    .sec_tick (sec_tick),
    .load_err (load_err),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  an;
    logic [23:0] t;
    logic        tick;
    logic        dp;
  } run_vec_t;

  typedef struct {
    logic [2:0]  sel;
    logic [3:0]  val;
    logic        err;
    logic [23:0] t;
  } ld_vec_t;

  run_vec_t rv[24];
  ld_vec_t  lv[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [23:0] act,
                     input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_an(input logic [7:0] v);
    int k;
    k = 0;
    while (an !== v && k < 40) begin
      step();
      k++;
    end
    chk("wait_an", {16'h0, an}, {16'h0, v});
  endtask

  task automatic do_load(input logic [2:0] s,
                         input logic [3:0] v);
    set_mode = 1'b1;
    load     = 1'b1;
    load_sel = s;
    load_val = v;
    step();
  endtask

  initial begin
    // anode k-th after release: one digit per 4 cycles
    for (int k = 1; k <= 24; k++) begin
      rv[k-1].an   = ~(8'h01 << ((k - 1) / 4));
      rv[k-1].t    = (k >= 20) ? 24'h000002 :
                     (k >= 10) ? 24'h000001 : 24'h000000;
      rv[k-1].tick = (k == 10) || (k == 20);
      rv[k-1].dp   = !(((k - 1) / 4 == 2) || ((k - 1) / 4 == 4));
    end
    lv[0]  = '{3'd5, 4'd2,  1'b0, 24'h200002};
    lv[1]  = '{3'd4, 4'd3,  1'b0, 24'h230002};
    lv[2]  = '{3'd3, 4'd5,  1'b0, 24'h235002};
    lv[3]  = '{3'd2, 4'd9,  1'b0, 24'h235902};
    lv[4]  = '{3'd1, 4'd5,  1'b0, 24'h235952};
    lv[5]  = '{3'd0, 4'd8,  1'b0, 24'h235958};
    lv[6]  = '{3'd1, 4'd6,  1'b1, 24'h235958};
    lv[7]  = '{3'd7, 4'd0,  1'b1, 24'h235958};
    lv[8]  = '{3'd6, 4'd1,  1'b1, 24'h235958};
    lv[9]  = '{3'd4, 4'd4,  1'b1, 24'h235958};
    lv[10] = '{3'd5, 4'd3,  1'b1, 24'h235958};
    lv[11] = '{3'd0, 4'd10, 1'b1, 24'h235958};

    step();
    chk("rst_time", time_bcd, 24'h0);
    chk("rst_tick", {23'h0, sec_tick}, 24'h0);
    chk("rst_err", {23'h0, load_err}, 24'h0);
    chk("rst_an", {16'h0, an}, 24'hFF);
    chk("rst_seg", {17'h0, seg}, 24'h7F);
    chk("rst_dp", {23'h0, dp}, 24'h1);

    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      step();
      chk($sformatf("run%0d_an", k + 1), {16'h0, an}, {16'h0, rv[k].an});
      chk($sformatf("run%0d_t", k + 1), time_bcd, rv[k].t);
      chk($sformatf("run%0d_tick", k + 1), {23'h0, sec_tick},
          {23'h0, rv[k].tick});
      chk($sformatf("run%0d_dp", k + 1), {23'h0, dp}, {23'h0, rv[k].dp});
      chk($sformatf("run%0d_seg", k + 1), {17'h0, seg}, 24'h40);
    end

    for (int k = 0; k < 12; k++) begin
      do_load(lv[k].sel, lv[k].val);
      chk($sformatf("ld%0d_t", k), time_bcd, lv[k].t);
      chk($sformatf("ld%0d_err", k), {23'h0, load_err},
          {23'h0, lv[k].err});
    end

    // 23:59:58 -> 23:59:59 -> 00:00:00
    set_mode = 1'b0;
    load     = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 9) chk("wrap_pre", time_bcd, 24'h235958);
      if (k == 10) begin
        chk("wrap_59", time_bcd, 24'h235959);
        chk("wrap_tick1", {23'h0, sec_tick}, 24'h1);
      end
      if (k == 11) chk("wrap_tick0", {23'h0, sec_tick}, 24'h0);
      if (k == 19) chk("wrap_hold", time_bcd, 24'h235959);
      if (k == 20) begin
        chk("wrap_00", time_bcd, 24'h000000);
        chk("wrap_tick2", {23'h0, sec_tick}, 24'h1);
      end
    end

    // h tens = 2 with h ones = 5 forces h ones to 0
    do_load(3'd4, 4'd5);
    chk("h1_5", time_bcd, 24'h050000);
    do_load(3'd5, 4'd2);
    chk("h10_2", time_bcd, 24'h200000);
    chk("h10_2_err", {23'h0, load_err}, 24'h0);

    // load in run mode is ignored silently
    set_mode = 1'b0;
    load     = 1'b1;
    load_sel = 3'd0;
    load_val = 4'd3;
    step();
    chk("runld_t", time_bcd, 24'h200000);
    chk("runld_err", {23'h0, load_err}, 24'h0);
    load = 1'b0;

    // set_mode rises on the terminal-count edge
    set_mode = 1'b1;
    step();
    set_mode = 1'b0;
    repeat (9) step();
    set_mode = 1'b1;
    step();
    chk("tc_set_t", time_bcd, 24'h200000);
    chk("tc_set_tick", {23'h0, sec_tick}, 24'h0);
    step();
    chk("tc_set_tick2", {23'h0, sec_tick}, 24'h0);
    set_mode = 1'b0;
    repeat (9) step();
    chk("fall_9", time_bcd, 24'h200000);
    step();
    chk("fall_10", time_bcd, 24'h200001);
    chk("fall_tick", {23'h0, sec_tick}, 24'h1);
    step();
    chk("fall_tick0", {23'h0, sec_tick}, 24'h0);

    // 12:34:56, then reset while digit 3 is shown
    do_load(3'd5, 4'd1);
    do_load(3'd4, 4'd2);
    do_load(3'd3, 4'd3);
    do_load(3'd2, 4'd4);
    do_load(3'd1, 4'd5);
    do_load(3'd0, 4'd6);
    load     = 1'b0;
    load_sel = 3'd0;
    chk("set_123456", time_bcd, 24'h123456);
    wait_an(8'hFE);
    chk("cursor_dp", {23'h0, dp}, 24'h0);
    chk("d0_seg", {17'h0, seg}, 24'h02);
    wait_an(8'hF7);
    chk("d3_seg", {17'h0, seg}, 24'h30);
    chk("d3_dp", {23'h0, dp}, 24'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_t", time_bcd, 24'h0);
    chk("mid_rst_an", {16'h0, an}, 24'hFF);
    chk("mid_rst_seg", {17'h0, seg}, 24'h7F);
    chk("mid_rst_dp", {23'h0, dp}, 24'h1);
    chk("mid_rst_tick", {23'h0, sec_tick}, 24'h0);
    chk("mid_rst_err", {23'h0, load_err}, 24'h0);
    step();
    chk("hold_rst_an", {16'h0, an}, 24'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_core.md
# clock_core

Timekeeping back end of the LED clock: consumes digit writes from the time-setting front end, keeps hh:mm:ss in BCD, and drives the multiplexed 7-segment display. It sits between the setting logic (mode switch plus digit-increment buttons) and the board display pins. It counts when in run mode, accepts digit loads only in set mode, and scans six digits continuously.

## Interface
- CLK_HZ, 100_000_000, clock cycles per second; prescaler terminal count is CLK_HZ-1.
- SCAN_DIV, 100_000, clock cycles each display digit stays selected.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- set_mode  in  1  1 = set mode (counting frozen, loads accepted); 0 = run mode.
- load  in  1  single-cycle write strobe, honoured only while set_mode=1.
- load_sel  in  3  digit index: 0 = s ones, 1 = s tens, 2 = m ones, 3 = m tens, 4 = h ones, 5 = h tens; 6 and 7 are illegal.
- load_val  in  4  BCD value to write.
- time_bcd  out  24  {h tens, h ones, m tens, m ones, s tens, s ones}, 4 bits each.
- sec_tick  out  1  one-cycle pulse after each run-mode increment.
- load_err  out  1  one-cycle pulse when a load is rejected.
- an  out  8  active-low anodes; an[7:6] always 1.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.

## Operation
- Prescaler runs 0..CLK_HZ-1 in run mode. On the edge where it equals CLK_HZ-1, it returns to 0 and the time increments by one second.
- Carry chain: s ones 9→0 carries to s tens; s tens 5→0 carries to m; m follows the same rule; carry from minutes increments hours.
- Hours wrap from 23 to 00, so 23:59:59 → 00:00:00. Every digit changes on the same edge.
- In set mode the prescaler is held at 0, no increments occur, and sec_tick stays 0.
- A load in set mode writes load_val to digit load_sel.
- Digit limits: ones ≤ 9, s/m tens ≤ 5, h tens ≤ 2, and h ones ≤ 3 when h tens = 2.
- Rejected loads: a load exceeding its digit limit or with load_sel ≥ 6 leaves time unchanged and pulses load_err.
- Writing h tens = 2 while h ones > 3 is legal. It also forces h ones to 0 on the same edge.
- A load while set_mode=0 is ignored silently, with no load_err.
- Scanner: the index cycles 0..5. Each index is held for SCAN_DIV cycles, then 5 wraps to 0.
- For the active index i, an[i]=0, the other an bits are 1, and seg is the decode of digit i (values 10..15 blank).
- dp=0 on digits 2 and 4 (the separators). In set mode, dp is also 0 on digit load_sel (cursor).
- The scanner runs in both modes.

## Timing
- Reset values: time_bcd=0, prescaler=0, scan index=0, scan counter=0, sec_tick=0, load_err=0, an=8'hFF, seg=7'h7F, dp=1.
- Display outputs are registered. The first valid an/seg appears on the first edge after rst deasserts.
- Increment: time_bcd changes on the terminal-count edge. sec_tick is high for the following cycle only.
- The first run-mode increment occurs CLK_HZ cycles after reset release or after set_mode falls.
- Load: time_bcd reflects the write one cycle after the strobe edge. load_err asserts in that same cycle.
- An asserted load strobe is honoured every cycle, with no handshake back-pressure.
- Simultaneous set_mode rise and terminal count: set_mode wins, so no increment and no sec_tick.
- Reset mid-operation clears everything immediately (asynchronous), including a pending sec_tick.
- An, seg and dp always change on the same edge, so no ghosting mix of old and new digits occurs.

## Structure
- clock_pkg holds digit-index constants (DIG_S1..DIG_H10), the per-digit limit constants, and a seg7 decode function (BCD → active-low segments, blank for >9).
- Sub-module seg7_scan contains the scan counter, index, anode/segment/dp registers, and is parameterised by SCAN_DIV.
- clock_core keeps the prescaler, BCD counters and load/validation logic.

## Test plan
- Use CLK_HZ=10, SCAN_DIV=4. Release reset, run 10 cycles → time_bcd=24'h000001, sec_tick pulses once, an cycles FE,FD,FB,F7,EF,DF every 4 cycles.
- Set 23:59:58 via six loads, drop set_mode, run 20 cycles → time_bcd becomes 235959 then 000000.
- Set mode with h ones=5 loaded, then load h tens=2 → h tens=2, h ones=0, load_err=0.
- Load s tens=6, then load_sel=7 → time unchanged, load_err pulses once per strobe.
- Raise set_mode on the prescaler terminal-count cycle → no increment and no sec_tick. After the fall, the next increment comes exactly 10 cycles later.
- Assert rst mid-count at 12:34:56 while digit 3 is displayed → all outputs return to their reset values immediately.
